// File: rtl/food_spawner.sv
// food_spawner: samples a random value, maps it to a playfield cell, checks occupancy, publishes food or fails
module food_spawner #(
    parameter int RAND_W    = 7,
    parameter int COLS      = 10,
    parameter int CELLS     = 100,
    parameter int COORD_W   = 4,
    parameter int MAX_TRIES = 16
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic               i_Req,
    input  logic [RAND_W-1:0]  i_RandNum,
    output logic               o_QryValid,
    output logic [COORD_W-1:0] o_QryX,
    output logic [COORD_W-1:0] o_QryY,
    input  logic               i_QryAck,
    input  logic               i_QryHit,
    output logic [COORD_W-1:0] o_FoodX,
    output logic [COORD_W-1:0] o_FoodY,
    output logic               o_FoodValid,
    output logic               o_Busy,
    output logic               o_Done,
    output logic               o_Fail
);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [RAND_W-1:0] COLS_R   = RAND_W'(COLS);
    localparam logic [RAND_W:0]   CELLS_R  = (RAND_W + 1)'(CELLS);
    localparam logic [TRY_W-1:0]  TRIES_R  = TRY_W'(MAX_TRIES);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_QUERY  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    logic [2:0]         state_q, state_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [RAND_W-1:0]  rem_q, rem_d;
    logic [COORD_W-1:0] quo_q, quo_d;
    logic               qry_valid_q, qry_valid_d;
    logic [COORD_W-1:0] qry_x_q, qry_x_d, qry_y_q, qry_y_d;
    logic [COORD_W-1:0] food_x_q, food_x_d, food_y_q, food_y_d;
    logic               food_valid_q, food_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fail_q, fail_d;
    logic [TRY_W-1:0]   tries_inc;
    logic               exhausted;
    assign tries_inc = tries_q + 1'b1;
    assign exhausted = (tries_inc == TRIES_R);
    // Next-state logic: sample, divide by repeated subtraction, query, and retry accounting
    always_comb begin
        state_d      = state_q;
        tries_d      = tries_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        qry_valid_d  = qry_valid_q;
        qry_x_d      = qry_x_q;
        qry_y_d      = qry_y_q;
        food_x_d     = food_x_q;
        food_y_d     = food_y_q;
        food_valid_d = food_valid_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Req) begin
                    food_valid_d = 1'b0;
                    tries_d      = '0;
                    state_d      = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if ({1'b0, i_RandNum} >= CELLS_R) begin
                    tries_d = tries_inc;
                    fail_d  = exhausted;
                    state_d = exhausted ? S_IDLE : S_SAMPLE;
                end else begin
                    rem_d   = i_RandNum;
                    quo_d   = '0;
                    state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                if (rem_q >= COLS_R) begin
                    rem_d = rem_q - COLS_R;
                    quo_d = quo_q + 1'b1;
                end else begin
                    qry_x_d     = rem_q[COORD_W-1:0];
                    qry_y_d     = quo_q;
                    qry_valid_d = 1'b1;
                    state_d     = S_QUERY;
                end
            end
            S_QUERY: begin
                if (i_QryAck) begin
                    qry_valid_d = 1'b0;
                    if (!i_QryHit) begin
                        food_x_d     = qry_x_q;
                        food_y_d     = qry_y_q;
                        food_valid_d = 1'b1;
                        done_d       = 1'b1;
                        state_d      = S_DONE;
                    end else begin
                        tries_d = tries_inc;
                        fail_d  = exhausted;
                        state_d = exhausted ? S_IDLE : S_SAMPLE;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end
    // State and registered outputs; reset also drops any outstanding query
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q      <= S_IDLE;
            tries_q      <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            qry_valid_q  <= 1'b0;
            qry_x_q      <= '0;
            qry_y_q      <= '0;
            food_x_q     <= '0;
            food_y_q     <= '0;
            food_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tries_q      <= tries_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            qry_valid_q  <= qry_valid_d;
            qry_x_q      <= qry_x_d;
            qry_y_q      <= qry_y_d;
            food_x_q     <= food_x_d;
            food_y_q     <= food_y_d;
            food_valid_q <= food_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end
    assign o_QryValid  = qry_valid_q;
    assign o_QryX      = qry_x_q;
    assign o_QryY      = qry_y_q;
    assign o_FoodX     = food_x_q;
    assign o_FoodY     = food_y_q;
    assign o_FoodValid = food_valid_q;
    assign o_Busy      = busy_q;
    assign o_Done      = done_q;
    assign o_Fail      = fail_q;
endmodule

// File: tb/tb_food_spawner.sv
// tb_food_spawner: directed and randomized checks of food_spawner against a behavioural model
module tb_food_spawner;
    localparam int COLS = 10;
    localparam int CELLS = 100;
    localparam int MAX_TRIES = 16;
    localparam int P_IDLE = 0, P_SAMP = 1, P_DIV = 2, P_QRY = 3, P_DONE = 4;
    logic       clk = 1'b0;
    logic       rst, req, ack, hit;
    logic [6:0] rnd;
    logic       o_qv, o_fv, o_busy, o_done, o_fail;
    logic [3:0] o_qx, o_qy, o_fx, o_fy;
    int n_chk = 0, n_fail = 0;
    int ph = P_IDLE, tries = 0, cnt = 0, px = 0, py = 0;
    int m_qv = 0, m_qx = 0, m_qy = 0, m_fv = 0, m_fx = 0, m_fy = 0;
    int m_busy = 0, m_done = 0, m_fail = 0;
    int r_done_cyc, r_done_cnt, r_fail_cyc, r_fail_cnt, r_qv_cyc, r_busy_all;
    int r_qx[$], r_qy[$];
    food_spawner dut (
        .i_Clk(clk), .i_Rst(rst), .i_Req(req), .i_RandNum(rnd),
        .o_QryValid(o_qv), .o_QryX(o_qx), .o_QryY(o_qy),
        .i_QryAck(ack), .i_QryHit(hit),
        .o_FoodX(o_fx), .o_FoodY(o_fy), .o_FoodValid(o_fv),
        .o_Busy(o_busy), .o_Done(o_done), .o_Fail(o_fail)
    );
    always #5 clk = ~clk;
    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic reject();
        tries++;
        if (tries == MAX_TRIES) begin
            m_fail = 1;
            ph = P_IDLE;
        end else ph = P_SAMP;
    endtask
    task automatic model_step();
        int r;
        r = int'(rnd);
        m_done = 0;
        m_fail = 0;
        if (rst) begin
            ph = P_IDLE; tries = 0;
            m_qv = 0; m_qx = 0; m_qy = 0; m_fv = 0; m_fx = 0; m_fy = 0;
        end else begin
            case (ph)
                P_IDLE: if (req) begin m_fv = 0; tries = 0; ph = P_SAMP; end
                P_SAMP: begin
                    if (r >= CELLS) reject();
                    else begin
                        px = r % COLS; py = r / COLS; cnt = py + 1; ph = P_DIV;
                    end
                end
                P_DIV: begin
                    cnt--;
                    if (cnt == 0) begin m_qv = 1; m_qx = px; m_qy = py; ph = P_QRY; end
                end
                P_QRY: begin
                    if (ack) begin
                        m_qv = 0;
                        if (!hit) begin
                            m_fx = m_qx; m_fy = m_qy; m_fv = 1; m_done = 1; ph = P_DONE;
                        end else reject();
                    end
                end
                default: ph = P_IDLE;
            endcase
        end
        m_busy = (ph != P_IDLE) ? 1 : 0;
    endtask
    task automatic compare();
        chk("qry_valid", int'(o_qv), m_qv);
        chk("qry_x", int'(o_qx), m_qx);
        chk("qry_y", int'(o_qy), m_qy);
        chk("food_valid", int'(o_fv), m_fv);
        chk("food_x", int'(o_fx), m_fx);
        chk("food_y", int'(o_fy), m_fy);
        chk("busy", int'(o_busy), m_busy);
        chk("done", int'(o_done), m_done);
        chk("fail", int'(o_fail), m_fail);
    endtask
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask
    task automatic run_txn(input int rs[$], input int hs[$], input int extra_at);
        int k;
        logic pqv;
        r_done_cyc = 0; r_done_cnt = 0; r_fail_cyc = 0; r_fail_cnt = 0;
        r_qv_cyc = 0; r_busy_all = 1;
        r_qx.delete(); r_qy.delete();
        req = 1; ack = 0; hit = 0; rnd = 7'($urandom);
        tick();
        req = 0;
        pqv = 1'b0;
        for (k = 1; k <= 60; k++) begin
            if (ph == P_SAMP && rs.size() > 0) rnd = 7'(rs.pop_front());
            else rnd = 7'($urandom);
            req = (k == extra_at);
            ack = (m_qv != 0);
            hit = (ack && hs.size() > 0) ? hs.pop_front() != 0 : 1'b0;
            tick();
            if (o_done) begin r_done_cnt++; r_done_cyc = k + 1; end
            if (o_fail) begin r_fail_cnt++; r_fail_cyc = k + 1; end
            if (o_qv && !pqv) begin
                r_qx.push_back(int'(o_qx)); r_qy.push_back(int'(o_qy));
                if (r_qv_cyc == 0) r_qv_cyc = k + 1;
            end
            pqv = o_qv;
            if (ph == P_IDLE) break;
            if (!o_busy) r_busy_all = 0;
        end
        req = 0; ack = 0; hit = 0;
        repeat (3) begin
            tick();
            if (o_done) r_done_cnt++;
            if (o_fail) r_fail_cnt++;
        end
    endtask
    initial begin
        int q127[$];
        int hold_cnt;
        rst = 1; req = 0; ack = 0; hit = 0; rnd = '0;
        tick(); tick();
        rst = 0;
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_food_valid", int'(o_fv), 0);
        chk("rst_qry_valid", int'(o_qv), 0);
        // basic placement: 37 -> (7,3), done 7 cycles after request
        run_txn('{37}, '{0}, 0);
        chk("t1_qv_cycle", r_qv_cyc, 6);
        chk("t1_nq", r_qx.size(), 1);
        if (r_qx.size() == 1) begin
            chk("t1_qx", r_qx[0], 7); chk("t1_qy", r_qy[0], 3);
        end
        chk("t1_done_cycle", r_done_cyc, 7);
        chk("t1_done_cnt", r_done_cnt, 1);
        chk("t1_food_x", int'(o_fx), 7);
        chk("t1_food_y", int'(o_fy), 3);
        chk("t1_food_valid", int'(o_fv), 1);
        // out-of-range first sample rejected silently
        run_txn('{115, 42}, '{0}, 0);
        chk("t2_nq", r_qx.size(), 1);
        if (r_qx.size() == 1) begin
            chk("t2_qx", r_qx[0], 2); chk("t2_qy", r_qy[0], 4);
        end
        chk("t2_qv_cycle", r_qv_cyc, 8);
        chk("t2_food_x", int'(o_fx), 2);
        chk("t2_food_y", int'(o_fy), 4);
        // occupied cell then corner cell
        run_txn('{0, 99}, '{1, 0}, 0);
        chk("t3_nq", r_qx.size(), 2);
        if (r_qx.size() == 2) begin
            chk("t3_q0x", r_qx[0], 0); chk("t3_q0y", r_qy[0], 0);
            chk("t3_q1x", r_qx[1], 9); chk("t3_q1y", r_qy[1], 9);
        end
        chk("t3_food_x", int'(o_fx), 9);
        chk("t3_food_y", int'(o_fy), 9);
        chk("t3_busy_all", r_busy_all, 1);
        chk("t3_done_cnt", r_done_cnt, 1);
        // exhaust all tries with out-of-range values
        for (int i = 0; i < 16; i++) q127.push_back(127);
        run_txn(q127, '{}, 0);
        chk("t4_fail_cnt", r_fail_cnt, 1);
        chk("t4_fail_cycle", r_fail_cyc, 17);
        chk("t4_nq", r_qx.size(), 0);
        chk("t4_food_valid", int'(o_fv), 0);
        chk("t4_food_x_kept", int'(o_fx), 9);
        chk("t4_food_y_kept", int'(o_fy), 9);
        chk("t4_busy", int'(o_busy), 0);
        chk("t4_done_cnt", r_done_cnt, 0);
        // withheld ack, then reset mid-query, then late ack
        req = 1; tick(); req = 0; rnd = 7'd55; tick();
        hold_cnt = 0;
        while (m_qv == 0 && hold_cnt < 30) begin rnd = 7'($urandom); tick(); hold_cnt++; end
        chk("t5_reached_query", int'(o_qv), 1);
        repeat (20) tick();
        chk("t5_hold_valid", int'(o_qv), 1);
        chk("t5_hold_x", int'(o_qx), 5);
        chk("t5_hold_y", int'(o_qy), 5);
        rst = 1; tick(); rst = 0;
        chk("t5_rst_qv", int'(o_qv), 0);
        chk("t5_rst_qx", int'(o_qx), 0);
        chk("t5_rst_fx", int'(o_fx), 0);
        chk("t5_rst_busy", int'(o_busy), 0);
        ack = 1; hit = 0; tick(); tick(); ack = 0;
        chk("t5_late_ack_busy", int'(o_busy), 0);
        chk("t5_late_ack_fv", int'(o_fv), 0);
        run_txn('{42}, '{0}, 0);
        chk("t5_after_done", r_done_cnt, 1);
        chk("t5_after_fx", int'(o_fx), 2);
        chk("t5_after_fy", int'(o_fy), 4);
        // second request during DIVIDE is ignored
        run_txn('{73}, '{0}, 3);
        chk("t6_done_cnt", r_done_cnt, 1);
        chk("t6_food_x", int'(o_fx), 3);
        chk("t6_food_y", int'(o_fy), 7);
        // randomized traffic against the model
        begin
            logic hi;
            hi = 1'b0;
            for (int c = 0; c < 20000; c++) begin
                if (c % 256 == 0) hi = ($urandom_range(0, 3) == 0);
                rst = ($urandom_range(0, 499) == 0);
                req = ($urandom_range(0, 7) == 0);
                rnd = hi ? 7'($urandom_range(100, 127)) : 7'($urandom);
                ack = ($urandom_range(0, 2) != 0);
                hit = ($urandom_range(0, 3) == 0);
                tick();
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
